sfifo_level: RTL and testbench
==============================

Name: sfifo_level

Overview:
- Next-generation synchronous FIFO for the FFT-demo datapath, sitting between sample producers and FFT/display consumers.
- First-word-fall-through: the head-of-queue word is always visible on o_data.
- Parametrised width and depth.
- Adds to the basic FIFO:
  - exported fill level
  - run-time programmable almost-full / almost-empty thresholds
  - synchronous flush
  - separate sticky overflow/underflow flags with software clear

Parameters:
- BW, 8, data width in bits
- LGFLEN, 4, log2 of depth; FLEN = 2^LGFLEN entries; legal range 1..12

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_flush  in  1  synchronous flush: empties FIFO
- i_wr  in  1  write request
- i_data  in  BW  write data
- o_full  out  1  fill == FLEN
- i_rd  in  1  read request; pops the word on o_data
- o_data  out  BW  head-of-queue data (FWFT); undefined when empty
- o_empty  out  1  fill == 0
- o_fill  out  LGFLEN+1  current number of stored entries
- i_af_level  in  LGFLEN+1  almost-full threshold
- i_ae_level  in  LGFLEN+1  almost-empty threshold
- o_afull  out  1  o_fill >= i_af_level
- o_aempty  out  1  o_fill <= i_ae_level
- i_clr_err  in  1  clear sticky error flags
- o_ovfl  out  1  sticky: write attempted while full and not reading
- o_unfl  out  1  sticky: read attempted while empty

Behaviour:
- Reset (i_reset_n low, async) sets:
  - wraddr=0, rdaddr=0, o_fill=0
  - o_empty=1, o_full=0, o_ovfl=0, o_unfl=0
  - o_aempty and o_afull follow their combinational definitions with fill 0
- Pointers are LGFLEN+1 bits wide with a wrap bit. Memory is indexed by the low LGFLEN bits.
- Write accept: wr_ok = i_wr && (!o_full || i_rd).
  - Write while full is accepted only with a concurrent read.
- Read accept: rd_ok = i_rd && !o_empty.
  - Read while empty is rejected even with a concurrent write; no write-through bypass.
- On wr_ok: mem[wraddr] <= i_data; wraddr++.
- On rd_ok: rdaddr++.
- o_fill next value (modulo arithmetic not needed, never exceeds FLEN):
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged on both or neither
- o_full and o_empty are registered, computed from next fill. They are valid the same cycle o_fill updates.
- o_data = mem[rdaddr]:
  - combinational read, zero-latency head visibility
  - a word written at edge N appears on o_data after edge N when the FIFO was empty
- o_afull / o_aempty are combinational compares of registered o_fill against the threshold inputs.
  - Thresholds may change at any time; outputs track the same cycle.
  - Threshold values > FLEN are legal: afull never asserts; aempty always asserts.
- Errors:
  - o_ovfl sets when i_wr && o_full && !i_rd.
  - o_unfl sets when i_rd && o_empty.
  - Both are sticky until reset or i_clr_err.
  - If set and clear coincide, set wins.
- i_flush has priority over wr/rd:
  - pointers and fill go to 0, o_empty=1, o_full=0
  - a coincident wr/rd is discarded and raises no error
  - error flags are not cleared by flush
- Wrap-around: pointers wrap naturally at 2^(LGFLEN+1). Full/empty never derive from pointer equality alone; fill is authoritative.
- Invariants:
  - o_fill == wraddr - rdaddr
  - o_fill <= FLEN
  - o_full and o_empty never both high

Optional Feature:
- Macro SFIFO_LEVEL_PEAK_EN.
- Defined:
  - adds output o_peak (LGFLEN+1 bits), a high-water mark holding the maximum o_fill seen since reset or since the last i_clr_err
  - reset value 0; updates one cycle after o_fill exceeds it
  - i_clr_err loads o_peak with the current o_fill
  - flush does not clear it
- Undefined:
  - port o_peak is absent; no peak logic is generated

Decomposition:
- Package sfifo_pkg holds:
  - function for FLEN from LGFLEN
  - localparam for pointer width LGFLEN+1
  - shared error-flag bit positions, reused by the future async FIFO
- Sub-module sfifo_mem: dual-port register array with one write port and one asynchronous read port, parametrised BW/LGFLEN.
- Control, pointers, fill and flags stay in sfifo_level.

Test Plan (BW=8, LGFLEN=2, FLEN=4):
- Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles → o_fill 1,2,3,4; o_full=1 after 4th edge; o_data=0x11 throughout.
- Full, then i_wr=1 i_rd=1 with data 0x55 → fill stays 4; o_data becomes 0x22; o_ovfl=0. Next cycle, i_wr alone → o_ovfl=1, fill 4, memory unchanged.
- Empty, i_rd=1 i_wr=1 data 0xA5 → o_unfl=1, fill=1, o_data=0xA5. Then i_clr_err=1 → o_unfl=0.
- i_af_level=3, i_ae_level=1, fill 0→4→0 → o_aempty high at fill 0..1; o_afull high at fill 3..4; change i_af_level to 5 at fill 4 → o_afull drops same cycle.
- Fill to 3, assert i_flush with i_wr=1 → fill=0, o_empty=1, no error. Then wraparound: 10 push/pop pairs → o_data matches the pushed sequence, o_fill never > 4.
- Assert i_reset_n low mid-cycle with fill=2 → all outputs reach reset values immediately, without waiting for a clock edge. With SFIFO_LEVEL_PEAK_EN: o_peak=0 after reset, 4 after the fill in scenario 1.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared definitions for the synchronous (and future async) FIFO family:
// depth helper, pointer wrap-bit width and sticky error-flag bit positions.
package sfifo_pkg;

  // Pointers carry one extra wrap bit above the memory index:
  // pointer width = LGFLEN + SFIFO_PTR_EXTRA.
  localparam int SFIFO_PTR_EXTRA = 1;

  // Bit positions inside the sticky error vector.
  localparam int SFIFO_ERR_OVFL = 0;
  localparam int SFIFO_ERR_UNFL = 1;
  localparam int SFIFO_ERR_W    = 2;

  // Number of entries for a given log2 depth.
  function automatic int sfifo_flen(input int lgflen);
    return 1 << lgflen;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Dual-port register array: one synchronous write port, one asynchronous
// read port so the FIFO head is visible with zero latency.
module sfifo_mem
  import sfifo_pkg::*;
#(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LGFLEN-1:0] waddr,
  input  logic [BW-1:0]     wdata,
  input  logic [LGFLEN-1:0] raddr,
  output logic [BW-1:0]     rdata
);

  localparam int FLEN = sfifo_flen(LGFLEN);

  logic [BW-1:0] mem [FLEN];

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_level.sv
// First-word-fall-through synchronous FIFO with exported fill level,
// programmable almost-full/almost-empty thresholds, synchronous flush and
// sticky overflow/underflow flags. Optional high-water mark output o_peak
// is built when SFIFO_LEVEL_PEAK_EN is defined.
module sfifo_level
  import sfifo_pkg::*;
#(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_full,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_fill,
  input  logic [LGFLEN:0]   i_af_level,
  input  logic [LGFLEN:0]   i_ae_level,
  output logic              o_afull,
  output logic              o_aempty,
  input  logic              i_clr_err,
  output logic              o_ovfl,
  output logic              o_unfl
`ifdef SFIFO_LEVEL_PEAK_EN
  ,
  output logic [LGFLEN:0]   o_peak
`endif
);

  localparam int FLEN = sfifo_flen(LGFLEN);
  localparam int PW   = LGFLEN + SFIFO_PTR_EXTRA;

  logic [PW-1:0]          wraddr, rdaddr;
  logic [PW-1:0]          fill_nxt;
  logic                   wr_ok, rd_ok, mem_we;
  logic [SFIFO_ERR_W-1:0] err, err_set;

  // Handshake: write while full only with a concurrent pop; no write-through
  // on empty. Flush suppresses both transfers and their error reporting.
  always_comb begin
    wr_ok   = i_wr && (!o_full || i_rd);
    rd_ok   = i_rd && !o_empty;
    mem_we  = wr_ok && !i_flush;
    err_set = '0;
    err_set[SFIFO_ERR_OVFL] = !i_flush && i_wr && o_full && !i_rd;
    err_set[SFIFO_ERR_UNFL] = !i_flush && i_rd && o_empty;
    fill_nxt = o_fill;
    if (i_flush)            fill_nxt = '0;
    else if (wr_ok && !rd_ok) fill_nxt = o_fill + PW'(1);
    else if (rd_ok && !wr_ok) fill_nxt = o_fill - PW'(1);
  end

  // Pointers, fill and registered full/empty; fill is the sole authority.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wraddr  <= '0;
      rdaddr  <= '0;
      o_fill  <= '0;
      o_empty <= 1'b1;
      o_full  <= 1'b0;
    end else begin
      if (i_flush) begin
        wraddr <= '0;
        rdaddr <= '0;
      end else begin
        if (wr_ok) wraddr <= wraddr + PW'(1);
        if (rd_ok) rdaddr <= rdaddr + PW'(1);
      end
      o_fill  <= fill_nxt;
      o_empty <= (fill_nxt == '0);
      o_full  <= (fill_nxt == PW'(FLEN));
    end
  end

  // Sticky error flags; a coincident set beats the software clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) err <= '0;
    else            err <= (i_clr_err ? '0 : err) | err_set;
  end

  assign o_ovfl   = err[SFIFO_ERR_OVFL];
  assign o_unfl   = err[SFIFO_ERR_UNFL];
  assign o_afull  = (o_fill >= i_af_level);
  assign o_aempty = (o_fill <= i_ae_level);

`ifdef SFIFO_LEVEL_PEAK_EN
  // High-water mark: clear reloads with current fill, otherwise track max.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)           o_peak <= '0;
    else if (i_clr_err)       o_peak <= o_fill;
    else if (o_fill > o_peak) o_peak <= o_fill;
  end
`endif

  sfifo_mem #(.BW(BW), .LGFLEN(LGFLEN)) u_mem (
    .clk   (i_clk),
    .we    (mem_we),
    .waddr (wraddr[LGFLEN-1:0]),
    .wdata (i_data),
    .raddr (rdaddr[LGFLEN-1:0]),
    .rdata (o_data)
  );

endmodule

// File: tb/tb_sfifo_level.sv
// Bench for sfifo_level (BW=8, LGFLEN=2): directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
// Build with SFIFO_LEVEL_PEAK_EN defined to also cover o_peak.
module tb_sfifo_level;

  localparam int BW = 8;
  localparam int LG = 2;
  localparam int F  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, wr, rd, clr;
  logic [BW-1:0] din;
  logic [LG:0]   af, ae;
  logic          full, empty, afull, aempty, ovfl, unfl;
  logic [BW-1:0] dout;
  logic [LG:0]   fill;
`ifdef SFIFO_LEVEL_PEAK_EN
  logic [LG:0]   peak;
`endif

  sfifo_level #(.BW(BW), .LGFLEN(LG)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_wr(wr), .i_data(din),
    .o_full(full), .i_rd(rd), .o_data(dout), .o_empty(empty), .o_fill(fill),
    .i_af_level(af), .i_ae_level(ae), .o_afull(afull), .o_aempty(aempty),
    .i_clr_err(clr), .o_ovfl(ovfl), .o_unfl(unfl)
`ifdef SFIFO_LEVEL_PEAK_EN
    , .o_peak(peak)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q[$];
  int m_ovfl, m_unfl, m_peak;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovfl = 0; m_unfl = 0; m_peak = 0;
  endtask

  // Compare every output against the model given current thresholds.
  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    chk({tag, ".fill"},   int'(fill),   n);
    chk({tag, ".empty"},  int'(empty),  int'(n == 0));
    chk({tag, ".full"},   int'(full),   int'(n == F));
    chk({tag, ".afull"},  int'(afull),  int'(n >= int'(af)));
    chk({tag, ".aempty"}, int'(aempty), int'(n <= int'(ae)));
    chk({tag, ".ovfl"},   int'(ovfl),   m_ovfl);
    chk({tag, ".unfl"},   int'(unfl),   m_unfl);
    if (n > 0) chk({tag, ".data"}, int'(dout), m_q[0]);
`ifdef SFIFO_LEVEL_PEAK_EN
    chk({tag, ".peak"},   int'(peak),   m_peak);
`endif
  endtask

  // One clock: apply inputs, advance model on the edge, check after it.
  task automatic cyc(input string tag, input bit w, input bit r,
                     input int d, input bit f, input bit c);
    int n;
    bit is_full, is_empty, set_o, set_u;
    wr = w; rd = r; din = BW'(d); flush = f; clr = c;
    @(posedge clk);
    n = m_q.size();
    is_full = (n == F); is_empty = (n == 0);
    set_o = !f && w && is_full && !r;
    set_u = !f && r && is_empty;
    if (c) m_peak = n; else if (n > m_peak) m_peak = n;
    m_ovfl = int'((m_ovfl != 0 && !c) || set_o);
    m_unfl = int'((m_unfl != 0 && !c) || set_u);
    if (f) m_q.delete();
    else begin
      if (r && !is_empty) void'(m_q.pop_front());
      if (w && (!is_full || r)) m_q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; wr = 0; rd = 0; clr = 0; din = '0;
    af = 3'd3; ae = 3'd1;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with four words; head stays 0x11.
    cyc("fill1", 1, 0, 'h11, 0, 0);
    cyc("fill2", 1, 0, 'h22, 0, 0);
    cyc("fill3", 1, 0, 'h33, 0, 0);
    cyc("fill4", 1, 0, 'h44, 0, 0);
    chk("s1.full", int'(full), 1);
    chk("s1.head", int'(dout), 'h11);

    // Full: write+read keeps fill, then lone write overflows.
    cyc("wr_rd_full", 1, 1, 'h55, 0, 0);
    chk("s2.head", int'(dout), 'h22);
    chk("s2.ovfl0", int'(ovfl), 0);
    cyc("ovfl", 1, 0, 'h66, 0, 0);
    chk("s2.ovfl1", int'(ovfl), 1);
`ifdef SFIFO_LEVEL_PEAK_EN
    chk("peak4", int'(peak), 4);
`endif

    // Drain (verifies 0x66 was not stored); aempty/afull tracked by check_all.
    for (int i = 0; i < 4; i++) cyc("drain", 0, 1, 0, 0, 0);
    cyc("clr_ovfl", 0, 0, 0, 0, 1);

    // Empty: read+write rejects read, accepts write, flags underflow.
    cyc("unfl", 1, 1, 'hA5, 0, 0);
    chk("s3.unfl", int'(unfl), 1);
    chk("s3.head", int'(dout), 'hA5);
    cyc("clr_unfl", 0, 0, 0, 0, 1);
    chk("s3.unfl_clr", int'(unfl), 0);

    // Threshold sweep 1..4, raise af above FLEN at full, then back to 0.
    for (int i = 0; i < 3; i++) cyc("up", 1, 0, 'h70 + i, 0, 0);
    af = 3'd5; #1;
    chk("af5.afull", int'(afull), 0);
    af = 3'd3; ae = 3'd7; #1;
    chk("ae7.aempty", int'(aempty), 1);
    ae = 3'd1;
    for (int i = 0; i < 4; i++) cyc("down", 0, 1, 0, 0, 0);

    // Flush with coincident write at fill 3: no store, no error.
    for (int i = 0; i < 3; i++) cyc("pre_flush", 1, 0, 'h80 + i, 0, 0);
    cyc("flush", 1, 1, 'h99, 1, 0);
    chk("flush.fill", int'(fill), 0);
    chk("flush.ovfl", int'(ovfl), 0);

    // Wraparound: push/pop pairs stepping the pointers past 2*FLEN.
    cyc("wrap_pre", 1, 0, 'hC0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc("wrap", 1, 1, 'hC0 + i, 0, 0);

    // Random traffic with occasional flush, clear and threshold changes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) af = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) ae = 3'($urandom_range(0, 7));
      cyc("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 255)), $urandom_range(0, 40) == 0,
          $urandom_range(0, 30) == 0);
    end

    // Asynchronous reset mid-cycle with fill 2.
    cyc("rst_pre_flush", 0, 0, 0, 1, 1);
    cyc("rst_pre1", 1, 0, 'hD1, 0, 0);
    cyc("rst_pre2", 1, 1, 'hD2, 0, 0);
    cyc("rst_pre3", 1, 0, 'hD3, 0, 0);
    cyc("rst_pre4", 1, 1, 'hD4, 0, 1);
    wr = 0; rd = 1; #2;
    rst_n = 1'b0; #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1; rd = 0;
    @(posedge clk); #1;
    check_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
